uart_frame_parser: RTL and testbench

- Consumes bytes from the UART receive stage through its `rx_data` and `rx_ready` outputs.
- Assembles fixed-format command frames: header, command, length, payload, checksum.
- Validates length and checksum, buffers the payload and presents the completed frame to the application under a valid/ack handshake.
- Flags malformed, timed-out and overrun frames with a one-cycle error pulse and code.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/frame_buf.sv | 29 ++
 rtl/uart_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CSUM,
        HOLD
    } state_t;

    typedef enum logic [2:0] {
        NO_ERR   = 3'd0,
        LEN_ERR  = 3'd1,
        CSUM_ERR = 3'd2,
        TIMEOUT  = 3'd3,
        OVERRUN  = 3'd4
    } err_t;

    localparam int         DEF_DATA_BIT = 8;
    localparam logic [7:0] DEF_HEADER   = 8'hAA;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module frame_buf #(
    parameter int MAX_LEN = 16,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles header/cmd/len/payload/checksum frames from UART receiver bytes
// and holds each good frame for the application under a valid/ack handshake.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         DATA_BIT     = DEF_DATA_BIT,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HEADER       = DEF_HEADER,
    parameter int         TIMEOUT_CLKS = 52080,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_BIT-1:0] rx_data,
    input  logic                rx_ready,
    output logic                frame_valid,
    output logic [7:0]          frame_cmd,
    output logic [7:0]          frame_len,
    input  logic [AW-1:0]       rd_addr,
    output logic [7:0]          rd_data,
    input  logic                frame_ack,
    output logic                frame_err,
    output logic [2:0]          err_code
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [DATA_BIT-1:0] hold_byte;
    logic                rdy_d;
    logic                byte_stb;
    logic [7:0]          byte_val;
    state_t              state;
    logic [7:0]          cmd;
    logic [7:0]          len;
    logic [7:0]          csum;
    logic [AW-1:0]       idx;
    logic [TW-1:0]       tmr;
    logic                wr_en;
    logic                tmr_active;
    logic                tmr_done;

    // rx_data is only meaningful in the stop bit; the last load while busy is the byte
    assign byte_stb   = rx_ready & ~rdy_d;
    assign byte_val   = 8'(hold_byte);
    assign wr_en      = byte_stb && (state == PAYLOAD);
    assign tmr_active = state inside {CMD, LEN, PAYLOAD, CSUM};
    assign tmr_done   = tmr_active && (tmr == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_byte   <= '0;
            rdy_d       <= 1'b1;
            state       <= HUNT;
            cmd         <= '0;
            len         <= '0;
            csum        <= '0;
            idx         <= '0;
            tmr         <= '0;
            frame_valid <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            err_code    <= '0;
        end else begin
            frame_err <= 1'b0;
            rdy_d     <= rx_ready;
            if (!rx_ready)
                hold_byte <= rx_data;
            if (tmr_active)
                tmr <= tmr + 1'b1;

            case (state)
                HUNT: begin
                    if (byte_stb && byte_val == HEADER) begin
                        state <= CMD;
                        tmr   <= '0;
                    end
                end
                CMD: begin
                    if (byte_stb) begin
                        cmd   <= byte_val;
                        csum  <= byte_val;
                        idx   <= '0;
                        tmr   <= '0;
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (byte_stb) begin
                        len  <= byte_val;
                        csum <= csum + byte_val;
                        tmr  <= '0;
                        if (byte_val > 8'(MAX_LEN)) begin
                            frame_err <= 1'b1;
                            err_code  <= LEN_ERR;
                            state     <= HUNT;
                        end else if (byte_val == 8'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_stb) begin
                        csum <= csum + byte_val;
                        tmr  <= '0;
                        if (8'(idx) == len - 8'd1) begin
                            idx   <= '0;
                            state <= CSUM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (byte_stb) begin
                        tmr <= '0;
                        if (byte_val == csum) begin
                            state       <= HOLD;
                            frame_valid <= 1'b1;
                            frame_cmd   <= cmd;
                            frame_len   <= len;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= CSUM_ERR;
                            state     <= HUNT;
                        end
                    end
                end
                HOLD: begin
                    // ack takes priority: a byte arriving with it is dropped silently
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        state       <= HUNT;
                    end else if (byte_stb) begin
                        frame_err <= 1'b1;
                        err_code  <= OVERRUN;
                    end
                end
                default: state <= HUNT;
            endcase

            if (tmr_done && !byte_stb) begin
                frame_err <= 1'b1;
                err_code  <= TIMEOUT;
                state     <= HUNT;
                tmr       <= '0;
            end
        end
    end

    frame_buf #(
        .MAX_LEN(MAX_LEN)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(idx),
        .wr_data(byte_val),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser using a simple receiver-interface model.
module tb_uart_frame_parser;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       frame_err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;
    int lat;
    logic [7:0] fr[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) pulses++;

    uart_frame_parser #(
        .DATA_BIT    (8),
        .MAX_LEN     (16),
        .HEADER      (8'hAA),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ack  (frame_ack),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge that consumes the strobe.
    task automatic send_byte(input logic [7:0] b, input logic with_ack);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        idle(4);
        rx_data = b;
        idle(2);
        rx_data   = 8'h00;
        rx_ready  = 1'b1;
        frame_ack = with_ack;
        idle(1);
        frame_ack = 1'b0;
    endtask

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i], 1'b0);
    endtask

    task automatic read_byte(input logic [3:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        idle(1);
        check(tag, rd_data, exp);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
        check("ack_clears_valid", frame_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0; rx_ready = 1'b1; rx_data = '0; frame_ack = 1'b0; rd_addr = '0;
        idle(3);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_cmd", frame_cmd, 8'h00);
        check("rst_len", frame_len, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_err", frame_err, 1'b0);
        check("rst_code", err_code, 3'd0);
        rst = 1'b1;
        idle(2);

        // good two-byte frame
        fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_frame();
        check("f1_valid", frame_valid, 1'b1);
        check("f1_cmd", frame_cmd, 8'h01);
        check("f1_len", frame_len, 8'h02);
        read_byte(4'd0, 8'h10, "f1_rd0");
        read_byte(4'd1, 8'h20, "f1_rd1");
        ack();
        idle(2);
        check("f1_no_err", pulses, 0);

        // garbage then zero-length frame
        fr = '{8'h13, 8'hFF, 8'hAA, 8'h05, 8'h00, 8'h05};
        send_frame();
        check("f2_valid", frame_valid, 1'b1);
        check("f2_cmd", frame_cmd, 8'h05);
        check("f2_len", frame_len, 8'h00);
        ack();
        idle(2);
        check("f2_no_err", pulses, 0);

        // bad checksum, then good frame
        fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_frame();
        check("csum_err_pulse", frame_err, 1'b1);
        check("csum_err_code", err_code, 3'd2);
        check("csum_valid", frame_valid, 1'b0);
        idle(1);
        check("csum_pulse_width", frame_err, 1'b0);
        fr = '{8'hAA, 8'h02, 8'h01, 8'h7F, 8'h82};
        send_frame();
        check("f3_valid", frame_valid, 1'b1);
        check("f3_cmd", frame_cmd, 8'h02);
        check("f3_len", frame_len, 8'h01);
        read_byte(4'd0, 8'h7F, "f3_rd0");
        ack();

        // length one beyond MAX_LEN
        fr = '{8'hAA, 8'h01, 8'h11};
        send_frame();
        check("len_err_pulse", frame_err, 1'b1);
        check("len_err_code", err_code, 3'd1);

        // timeout after AA 01
        fr = '{8'hAA, 8'h01};
        send_frame();
        lat = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            idle(1);
            if (frame_err) begin
                lat = i;
                break;
            end
        end
        check("timeout_latency", lat, TO);
        check("timeout_code", err_code, 3'd3);
        idle(2);

        // overrun while holding, then ack coinciding with a strobe
        fr = '{8'hAA, 8'h03, 8'h01, 8'h44, 8'h48};
        send_frame();
        check("f4_valid", frame_valid, 1'b1);
        base = pulses;
        send_byte(8'h55, 1'b0);
        check("ovr_pulse", frame_err, 1'b1);
        check("ovr_code", err_code, 3'd4);
        check("ovr_valid", frame_valid, 1'b1);
        check("ovr_cmd", frame_cmd, 8'h03);
        check("ovr_len", frame_len, 8'h01);
        read_byte(4'd0, 8'h44, "ovr_rd0");
        send_byte(8'h66, 1'b1);
        check("ackstb_valid", frame_valid, 1'b0);
        check("ackstb_err", frame_err, 1'b0);
        idle(2);
        check("ackstb_pulses", pulses, base + 1);
        check("ackstb_code_kept", err_code, 3'd4);
        fr = '{8'hAA, 8'h04, 8'h00, 8'h04};
        send_frame();
        check("f5_valid_hunt", frame_valid, 1'b1);
        check("f5_cmd", frame_cmd, 8'h04);
        ack();

        // reset in the middle of a payload
        fr = '{8'hAA, 8'h06, 8'h03, 8'h01};
        send_frame();
        base = pulses;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", frame_valid, 1'b0);
        check("mid_rst_cmd", frame_cmd, 8'h00);
        check("mid_rst_len", frame_len, 8'h00);
        check("mid_rst_code", err_code, 3'd0);
        check("mid_rst_rd", rd_data, 8'h00);
        idle(2);
        rst = 1'b1;
        idle(5);
        check("post_rst_quiet", pulses, base);
        check("post_rst_valid", frame_valid, 1'b0);
        fr = '{8'hAA, 8'h06, 8'h02, 8'h01, 8'h02, 8'h0B};
        send_frame();
        check("f6_valid", frame_valid, 1'b1);
        check("f6_cmd", frame_cmd, 8'h06);
        check("f6_len", frame_len, 8'h02);
        read_byte(4'd1, 8'h02, "f6_rd1");
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
